// File: rtl/rf_multiport.sv
//------------------------------------------------------------------------------
// Module  : rf_multiport
// Brief   : Dual-read / dual-write register file with write bypass, busy
//           scoreboard, debug read port and write statistics.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_multiport #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          busy1,
  output logic          busy2,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  input  logic [AW-1:0] reg_sel,
  output logic [DW-1:0] reg_data,
  output logic          wr_conflict,
  output logic [31:0]   wr_cnt
);

  localparam int c_DEPTH = 1 << AW;
  localparam bit c_ZERO  = (ZERO_REG != 0);
  localparam bit c_BYP   = (BYPASS != 0);

  logic [DW-1:0]      r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;
  logic               r_wr_conflict;
  logic [31:0]        r_wr_cnt;

  logic               w_wr0_ok;
  logic               w_wr1_ok;
  logic               w_conf;
  logic               w_wr0_commit;
  logic [1:0]         w_ncommit;

  // Writes to a hard-wired zero register are dropped before anything else sees them.
  assign w_wr0_ok     = we0 && !(c_ZERO && (wa0 == '0));
  assign w_wr1_ok     = we1 && !(c_ZERO && (wa1 == '0));
  assign w_conf       = w_wr0_ok && w_wr1_ok && (wa0 == wa1);
  assign w_wr0_commit = w_wr0_ok && !w_conf;
  assign w_ncommit    = {1'b0, w_wr1_ok} + {1'b0, w_wr0_commit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr0_commit) r_mem[wa0] <= wd0;
      if (w_wr1_ok)     r_mem[wa1] <= wd1;
    end
  end

  // A new issue outranks the clearing write of the previous producer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < c_DEPTH; i++) begin
        if (iss_en && (iss_addr == AW'(i)) && !(c_ZERO && (i == 0))) begin
          r_busy[i] <= 1'b1;
        end else if ((w_wr1_ok && (wa1 == AW'(i))) || (w_wr0_ok && (wa0 == AW'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_conflict <= 1'b0;
      r_wr_cnt      <= '0;
    end else begin
      r_wr_conflict <= w_conf;
      r_wr_cnt      <= r_wr_cnt + {30'd0, w_ncommit};
    end
  end

  // Bypass is suppressed during reset so the read ports show zero immediately.
  always_comb begin
    RD1 = r_mem[A1];
    if (c_ZERO && (A1 == '0))                       RD1 = '0;
    else if (c_BYP && rst && w_wr1_ok && (wa1 == A1)) RD1 = wd1;
    else if (c_BYP && rst && w_wr0_ok && (wa0 == A1)) RD1 = wd0;
  end

  always_comb begin
    RD2 = r_mem[A2];
    if (c_ZERO && (A2 == '0))                       RD2 = '0;
    else if (c_BYP && rst && w_wr1_ok && (wa1 == A2)) RD2 = wd1;
    else if (c_BYP && rst && w_wr0_ok && (wa0 == A2)) RD2 = wd0;
  end

  assign busy1       = r_busy[A1];
  assign busy2       = r_busy[A2];
  assign reg_data    = (c_ZERO && (reg_sel == '0)) ? '0 : r_mem[reg_sel];
  assign wr_conflict = r_wr_conflict;
  assign wr_cnt      = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rf_multiport.sv
//------------------------------------------------------------------------------
// Module  : tb_rf_multiport
// Brief   : Scoreboard bench for rf_multiport (bypass and non-bypass builds).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rf_multiport;

    logic        clk;
    logic        rst;
    logic [4:0]  A1, A2, wa0, wa1, iss_addr, reg_sel;
    logic [31:0] wd0, wd1;
    logic        we0, we1, iss_en;

    logic [31:0] RD1, RD2, reg_data, wr_cnt;
    logic        busy1, busy2, wr_conflict;

    logic [31:0] b_RD1, b_RD2, b_reg_data, b_wr_cnt;
    logic        b_busy1, b_busy2, b_wr_conflict;

    localparam int c_RD1 = 0, c_RD2 = 1, c_BUSY1 = 2, c_BUSY2 = 3;
    localparam int c_DBG = 4, c_CONF = 5, c_CNT = 6, c_B_RD1 = 7;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;
    event sample_ev;

    rf_multiport #(.DW(32), .AW(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .busy1(busy1), .busy2(busy2),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .reg_sel(reg_sel), .reg_data(reg_data),
        .wr_conflict(wr_conflict), .wr_cnt(wr_cnt)
    );

    rf_multiport #(.DW(32), .AW(5), .BYPASS(0), .ZERO_REG(1)) u_dut_nobyp (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(b_RD1), .RD2(b_RD2),
        .busy1(b_busy1), .busy2(b_busy2),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .reg_sel(reg_sel), .reg_data(b_reg_data),
        .wr_conflict(b_wr_conflict), .wr_cnt(b_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic exp_v(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic sample();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    endtask

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.sig)
                    c_RD1:   act = RD1;
                    c_RD2:   act = RD2;
                    c_BUSY1: act = {31'd0, busy1};
                    c_BUSY2: act = {31'd0, busy2};
                    c_DBG:   act = reg_data;
                    c_CONF:  act = {31'd0, wr_conflict};
                    c_CNT:   act = wr_cnt;
                    default: act = b_RD1;
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        A1 = '0; A2 = '0; reg_sel = '0; wa0 = '0; wa1 = '0; iss_addr = '0;
        wd0 = '0; wd1 = '0;
        idle();

        A1 = 5'd5; reg_sel = 5'd5;
        exp_v("reset_rd1", c_RD1, 32'h0);
        exp_v("reset_busy1", c_BUSY1, 32'h0);
        exp_v("reset_dbg", c_DBG, 32'h0);
        exp_v("reset_conf", c_CONF, 32'h0);
        exp_v("reset_cnt", c_CNT, 32'h0);
        sample();
        checks++;
        if (wr_cnt !== 32'h0 || RD1 !== 32'h0) begin
            errors++;
            $display("FAIL direct_reset: rd1=0x%08h cnt=0x%08h", RD1, wr_cnt);
        end
        @(negedge clk);
        rst = 1'b1;

        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678;
        exp_v("wr5_bypass", c_RD1, 32'h12345678);
        exp_v("wr5_dbg_before", c_DBG, 32'h0);
        exp_v("wr5_cnt_before", c_CNT, 32'h0);
        sample();
        tick(); idle();
        exp_v("wr5_stored", c_RD1, 32'h12345678);
        exp_v("wr5_dbg_after", c_DBG, 32'h12345678);
        exp_v("wr5_cnt", c_CNT, 32'd1);
        exp_v("wr5_noconf", c_CONF, 32'h0);
        sample();
        checks++;
        if (reg_data !== 32'h12345678) begin
            errors++;
            $display("FAIL direct_wr5_dbg: got 0x%08h", reg_data);
        end

        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA0000;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5555FFFF;
        A2 = 5'd7;
        exp_v("conf_bypass", c_RD2, 32'h5555FFFF);
        sample();
        tick(); idle();
        exp_v("conf_stored", c_RD2, 32'h5555FFFF);
        exp_v("conf_pulse", c_CONF, 32'h1);
        exp_v("conf_cnt", c_CNT, 32'd2);
        sample();
        checks++;
        if (wr_conflict !== 1'b1) begin
            errors++;
            $display("FAIL direct_conf_pulse: got %b", wr_conflict);
        end
        tick();
        exp_v("conf_pulse_end", c_CONF, 32'h0);
        sample();

        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        A1 = 5'd0; reg_sel = 5'd0;
        exp_v("r0_bypass", c_RD1, 32'h0);
        sample();
        tick(); idle();
        exp_v("r0_rd1", c_RD1, 32'h0);
        exp_v("r0_busy", c_BUSY1, 32'h0);
        exp_v("r0_cnt", c_CNT, 32'd2);
        exp_v("r0_conf", c_CONF, 32'h0);
        exp_v("r0_dbg", c_DBG, 32'h0);
        sample();

        iss_en = 1'b1; iss_addr = 5'd9; A1 = 5'd9;
        exp_v("sb_busy_before", c_BUSY1, 32'h0);
        sample();
        tick(); idle();
        exp_v("sb_busy_set", c_BUSY1, 32'h1);
        sample();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
        iss_en = 1'b1; iss_addr = 5'd9;
        tick(); idle();
        exp_v("sb_issue_wins", c_BUSY1, 32'h1);
        exp_v("sb_cnt3", c_CNT, 32'd3);
        sample();
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h1234;
        exp_v("sb_busy_nobypass", c_BUSY1, 32'h1);
        sample();
        tick(); idle();
        exp_v("sb_cleared", c_BUSY1, 32'h0);
        exp_v("sb_r9", c_RD1, 32'h1234);
        exp_v("sb_cnt4", c_CNT, 32'd4);
        sample();

        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44;
        A1 = 5'd3; A2 = 5'd4;
        tick(); idle();
        exp_v("dual_r3", c_RD1, 32'h33);
        exp_v("dual_r4", c_RD2, 32'h44);
        exp_v("dual_cnt", c_CNT, 32'd6);
        exp_v("dual_noconf", c_CONF, 32'h0);
        sample();

        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hDEADBEEF; A1 = 5'd2;
        exp_v("nobyp_old", c_B_RD1, 32'h0);
        exp_v("byp_new", c_RD1, 32'hDEADBEEF);
        sample();
        tick(); idle();
        exp_v("nobyp_new", c_B_RD1, 32'hDEADBEEF);
        exp_v("nobyp_cnt", c_CNT, 32'd7);
        sample();

        for (int i = 1; i < 32; i++) begin
            we1 = 1'b1; wa1 = 5'(i); wd1 = 32'h01010101 * i;
            iss_en = 1'b1; iss_addr = 5'(i);
            tick();
        end
        idle();
        A1 = 5'd31; A2 = 5'd17; reg_sel = 5'd31;
        exp_v("load_r31", c_RD1, 32'h1F1F1F1F);
        exp_v("load_busy31", c_BUSY1, 32'h1);
        exp_v("load_busy17", c_BUSY2, 32'h1);
        exp_v("load_dbg31", c_DBG, 32'h1F1F1F1F);
        exp_v("load_cnt", c_CNT, 32'd38);
        sample();
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h1;
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h2;
        tick(); idle();
        exp_v("pre_rst_conf", c_CONF, 32'h1);
        exp_v("pre_rst_cnt", c_CNT, 32'd39);
        sample();

        we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h00000BAD; A2 = 5'd20;
        #1;
        rst = 1'b0;
        exp_v("arst_rd1", c_RD1, 32'h0);
        exp_v("arst_rd2_pending", c_RD2, 32'h0);
        exp_v("arst_busy1", c_BUSY1, 32'h0);
        exp_v("arst_dbg", c_DBG, 32'h0);
        exp_v("arst_cnt", c_CNT, 32'h0);
        exp_v("arst_conf", c_CONF, 32'h0);
        sample();
        checks++;
        if (busy1 !== 1'b0 || wr_cnt !== 32'h0 || RD2 !== 32'h0) begin
            errors++;
            $display("FAIL direct_arst: busy1=%b cnt=0x%08h rd2=0x%08h", busy1, wr_cnt, RD2);
        end
        tick();
        exp_v("arst_write_ignored", c_RD2, 32'h0);
        sample();
        @(negedge clk);
        idle();
        rst = 1'b1;
        tick();
        exp_v("post_rst_r20", c_RD2, 32'h0);
        exp_v("post_rst_cnt", c_CNT, 32'h0);
        exp_v("post_rst_busy", c_BUSY2, 32'h0);
        sample();
        we1 = 1'b1; wa1 = 5'd20; wd1 = 32'h77;
        tick(); idle();
        exp_v("post_rst_write", c_RD2, 32'h77);
        exp_v("post_rst_cnt1", c_CNT, 32'd1);
        sample();
        checks++;
        if (RD2 !== 32'h77 || wr_cnt !== 32'd1) begin
            errors++;
            $display("FAIL direct_post_rst: rd2=0x%08h cnt=0x%08h", RD2, wr_cnt);
        end

        if (errors == 0) begin
            $display("PASS: all %0d checks passed", checks);
        end else begin
            $display("FAIL: errors=%0d of %0d checks", errors, checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
